// File: rtl/lcd_pattern_scheduler.sv
// Frame-synchronous RGB565 test-pattern source for the 800x480 panel path.
// Pixel coordinates are rebuilt from TG_DE/TG_VSYNC; pattern changes only at frame start.
module lcd_pattern_scheduler #(
   parameter int H_ACTIVE           = 800,
   parameter int V_ACTIVE           = 480,
   parameter int FRAMES_PER_PATTERN = 60,
   parameter int NUM_PATTERNS       = 5
) (
   input  logic        PixelClk,
   input  logic        RST,
   input  logic        TG_DE,
   input  logic        TG_HSYNC,
   input  logic        TG_VSYNC,
   input  logic        BTN_NEXT,
   input  logic        AUTO,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B,
   output logic [2:0]  PATTERN,
   output logic [15:0] FRAME_CNT
);
   localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_MAX    = 10'(V_ACTIVE - 1);
   localparam logic [15:0] FC_LAST  = 16'(FRAMES_PER_PATTERN - 1);
   localparam logic [2:0]  PAT_LAST = 3'(NUM_PATTERNS - 1);
   localparam int          BAR_W    = H_ACTIVE / 8;

   typedef enum logic [1:0] {WAIT_VS, SHOW, BLANK} state_t;

   state_t      state_p0;
   logic [2:0]  pattern_p0;
   logic [15:0] frame_cnt_p0;
   logic        pending_p0;
   logic [10:0] x_p0;
   logic [9:0]  y_p0;
   logic        vs_hist_p0;
   logic        de_hist_p0;

   logic        vld_p1;
   logic        hs_p1;
   logic        vs_p1;
   logic [15:0] rgb_p1;

   logic        fs;
   logic        de_fall;
   logic        auto_due;
   logic        advance;
   logic        take_sw;
   logic        show_sel;
   logic [2:0]  pat_inc;
   logic [2:0]  pat_sel;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
      return (v >= lim) ? lim : v + 16'd1;
   endfunction

   // Packed {R,G,B}; the bar index comes from a comparator chain instead of a divider.
   function automatic logic [15:0] pixel(input logic [2:0] pat, input logic [10:0] x,
                                         input logic [9:0] y);
      logic [2:0]  bar;
      logic [15:0] px;
      bar = 3'd0;
      for (int i = 1; i < 8; i++)
         if ({21'd0, x} >= i * BAR_W) bar = 3'(i);
      case (pat)
         3'd0: px = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
         3'd1: px = (x[4:0] == 5'd0 || y[4:0] == 5'd0 || x == X_MAX || y == Y_MAX) ?
                    16'hFFFF : 16'h0000;
         3'd2: px = {x[9:5], y[8:3], 5'd0};
         3'd3: px = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
         3'd4: px = {5'h1F, 6'd0, 5'd0};
         default: px = 16'h0000;
      endcase
      return px;
   endfunction

   assign fs       = vs_hist_p0 & ~TG_VSYNC;
   assign de_fall  = de_hist_p0 & ~TG_DE;
   assign auto_due = AUTO && (frame_cnt_p0 == FC_LAST);
   assign advance  = pending_p0 | BTN_NEXT | auto_due;
   assign take_sw  = fs && (state_p0 == SHOW) && advance;
   assign pat_inc  = (pattern_p0 == PAT_LAST) ? 3'd0 : pattern_p0 + 3'd1;
   assign pat_sel  = take_sw ? pat_inc : pattern_p0;
   // Pixels in the frame-start cycle already follow the state being entered.
   assign show_sel = fs ? !take_sw : (state_p0 == SHOW);

   always_ff @(posedge PixelClk) begin
      if (RST) begin
         state_p0     <= WAIT_VS;
         pattern_p0   <= 3'd0;
         frame_cnt_p0 <= 16'd0;
         pending_p0   <= 1'b0;
         x_p0         <= 11'd0;
         y_p0         <= 10'd0;
         vs_hist_p0   <= 1'b1;
         de_hist_p0   <= 1'b1;
         vld_p1       <= 1'b0;
         hs_p1        <= 1'b1;
         vs_p1        <= 1'b1;
         rgb_p1       <= 16'd0;
      end else begin
         // p0: sync history and coordinate recovery
         vs_hist_p0 <= TG_VSYNC;
         de_hist_p0 <= TG_DE;
         x_p0 <= TG_DE ? 11'(sat_inc({5'd0, x_p0}, {5'd0, X_MAX})) : 11'd0;
         if (fs)
            y_p0 <= 10'd0;
         else if (de_fall)
            y_p0 <= 10'(sat_inc({6'd0, y_p0}, {6'd0, Y_MAX}));

         if (BTN_NEXT) pending_p0 <= 1'b1;
         if (fs) begin
            if (auto_due) pending_p0 <= 1'b1;
            case (state_p0)
               WAIT_VS: state_p0 <= SHOW;
               SHOW: begin
                  if (advance) begin
                     state_p0     <= BLANK;
                     pattern_p0   <= pat_sel;
                     frame_cnt_p0 <= 16'd0;
                     pending_p0   <= 1'b0;
                  end else begin
                     frame_cnt_p0 <= sat_inc(frame_cnt_p0, 16'hFFFF);
                  end
               end
               BLANK:   state_p0 <= SHOW;
               default: state_p0 <= WAIT_VS;
            endcase
         end

         // p1: panel-aligned outputs
         vld_p1 <= TG_DE;
         hs_p1  <= TG_HSYNC;
         vs_p1  <= TG_VSYNC;
         rgb_p1 <= (TG_DE && show_sel) ? pixel(pat_sel, x_p0, y_p0) : 16'h0000;
      end
   end

   assign LCD_DE    = vld_p1;
   assign LCD_HSYNC = hs_p1;
   assign LCD_VSYNC = vs_p1;
   assign LCD_R     = rgb_p1[15:11];
   assign LCD_G     = rgb_p1[10:5];
   assign LCD_B     = rgb_p1[4:0];
   assign PATTERN   = pattern_p0;
   assign FRAME_CNT = frame_cnt_p0;

endmodule

// File: tb/tb_lcd_pattern_scheduler.sv
// Directed bench for lcd_pattern_scheduler using shortened frames built from TG_* strobes.
module tb_lcd_pattern_scheduler;
   logic        PixelClk = 1'b0;
   logic        RST = 1'b1;
   logic        TG_DE = 1'b0;
   logic        TG_HSYNC = 1'b1;
   logic        TG_VSYNC = 1'b1;
   logic        BTN_NEXT = 1'b0;
   logic        AUTO = 1'b0;
   logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic [2:0]  PATTERN;
   logic [15:0] FRAME_CNT;

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] rgb;
   logic [15:0] rgb_a;

   // Auto mode with 2 frames per pattern, indexed by frame-start number after reset.
   int   exp_pat[20] = '{0,0,1,1,1,2,2,2,3,3,3,4,4,4,0,0,0,1,1,1};
   bit   exp_blk[20] = '{0,0,1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1,0,0};
   logic [15:0] exp_rgb700[5] = '{16'hFFFF, 16'hFFFF, 16'hA800, 16'hFFFF, 16'hF800};

   lcd_pattern_scheduler #(
      .H_ACTIVE(800), .V_ACTIVE(480), .FRAMES_PER_PATTERN(2), .NUM_PATTERNS(5)
   ) dut (
      .PixelClk(PixelClk), .RST(RST), .TG_DE(TG_DE), .TG_HSYNC(TG_HSYNC),
      .TG_VSYNC(TG_VSYNC), .BTN_NEXT(BTN_NEXT), .AUTO(AUTO), .LCD_DE(LCD_DE),
      .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G),
      .LCD_B(LCD_B), .PATTERN(PATTERN), .FRAME_CNT(FRAME_CNT)
   );

   always #5 PixelClk = ~PixelClk;

   task automatic step();
      @(posedge PixelClk);
      #1;
   endtask

   task automatic frame_start(input logic btn);
      TG_VSYNC = 1'b0; BTN_NEXT = btn; step();
      BTN_NEXT = 1'b0; step();
      TG_VSYNC = 1'b1; step();
   endtask

   task automatic run_line(input int n, input int px, output logic [15:0] val);
      val = 16'hDEAD;
      for (int i = 0; i < n; i++) begin
         TG_DE = 1'b1; step();
         if (i == px) val = {LCD_R, LCD_G, LCD_B};
      end
      TG_DE = 1'b0; step(); step();
   endtask

   task automatic test_reset();
      RST = 1'b1; step(); step();
      n_cmp++; if (LCD_DE !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", LCD_DE); end
      n_cmp++; if (LCD_HSYNC !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b want 1", LCD_HSYNC); end
      n_cmp++; if (LCD_VSYNC !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b want 1", LCD_VSYNC); end
      n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== 16'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want 0000", {LCD_R, LCD_G, LCD_B}); end
      n_cmp++; if (PATTERN !== 3'd0) begin n_fail++; $display("FAIL reset_pat: got %0d want 0", PATTERN); end
      n_cmp++; if (FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d want 0", FRAME_CNT); end
      RST = 1'b0; step();
   endtask

   task automatic test_first_frames();
      run_line(701, 700, rgb);
      n_cmp++; if (rgb !== 16'h0) begin n_fail++; $display("FAIL wait_vs_black: got %h want 0000", rgb); end
      frame_start(1'b0);
      n_cmp++; if (PATTERN !== 3'd0) begin n_fail++; $display("FAIL f1_pat: got %0d want 0", PATTERN); end
      n_cmp++; if (FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL f1_fcnt: got %0d want 0", FRAME_CNT); end
      run_line(1, 0, rgb);
      n_cmp++; if (rgb !== 16'h0000) begin n_fail++; $display("FAIL bars_x0: got %h want 0000", rgb); end
      run_line(151, 150, rgb);
      n_cmp++; if (rgb !== 16'h001F) begin n_fail++; $display("FAIL bars_x150: got %h want 001f", rgb); end
      run_line(701, 700, rgb);
      n_cmp++; if (rgb !== 16'hFFFF) begin n_fail++; $display("FAIL bars_x700: got %h want ffff", rgb); end
      frame_start(1'b0);
      n_cmp++; if (FRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL f3_fcnt: got %0d want 1", FRAME_CNT); end
      n_cmp++; if (PATTERN !== 3'd0) begin n_fail++; $display("FAIL f3_pat: got %0d want 0", PATTERN); end
   endtask

   task automatic test_button();
      run_line(10, 0, rgb);
      BTN_NEXT = 1'b1; step();
      BTN_NEXT = 1'b0; step();
      n_cmp++; if (PATTERN !== 3'd0) begin n_fail++; $display("FAIL btn_mid_frame_pat: got %0d want 0", PATTERN); end
      frame_start(1'b0);
      n_cmp++; if (PATTERN !== 3'd1) begin n_fail++; $display("FAIL btn_pat: got %0d want 1", PATTERN); end
      n_cmp++; if (FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL btn_fcnt: got %0d want 0", FRAME_CNT); end
      run_line(701, 700, rgb);
      n_cmp++; if (rgb !== 16'h0) begin n_fail++; $display("FAIL blank_black: got %h want 0000", rgb); end
      frame_start(1'b0);
      n_cmp++; if (FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL after_blank_fcnt: got %0d want 0", FRAME_CNT); end
      run_line(1, 0, rgb);
      n_cmp++; if (rgb !== 16'hFFFF) begin n_fail++; $display("FAIL grid_0_0: got %h want ffff", rgb); end
      run_line(2, 1, rgb);
      n_cmp++; if (rgb !== 16'h0000) begin n_fail++; $display("FAIL grid_1_1: got %h want 0000", rgb); end
      for (int l = 2; l < 5; l++) run_line(1, 0, rgb_a);
      run_line(33, 32, rgb);
      n_cmp++; if (rgb !== 16'hFFFF) begin n_fail++; $display("FAIL grid_32_5: got %h want ffff", rgb); end
   endtask

   task automatic test_back_to_back_requests();
      for (int k = 0; k < 3; k++) begin
         BTN_NEXT = 1'b1; step();
         BTN_NEXT = 1'b0; run_line(3, 0, rgb_a);
      end
      frame_start(1'b1);
      n_cmp++; if (PATTERN !== 3'd2) begin n_fail++; $display("FAIL collapse_pat: got %0d want 2", PATTERN); end
      frame_start(1'b0);
      n_cmp++; if (PATTERN !== 3'd2) begin n_fail++; $display("FAIL collapse_show_pat: got %0d want 2", PATTERN); end
      frame_start(1'b0);
      n_cmp++; if (PATTERN !== 3'd2) begin n_fail++; $display("FAIL collapse_next_pat: got %0d want 2", PATTERN); end
      n_cmp++; if (FRAME_CNT !== 16'd1) begin n_fail++; $display("FAIL collapse_fcnt: got %0d want 1", FRAME_CNT); end
   endtask

   task automatic test_gradient_timing();
      for (int l = 0; l < 479; l++) run_line(1, 0, rgb_a);
      for (int i = 0; i < 800; i++) begin
         TG_DE = 1'b1;
         if (i == 0) begin
            n_cmp++; if (LCD_DE !== 1'b0) begin n_fail++; $display("FAIL de_not_early: got %b want 0", LCD_DE); end
         end
         step();
         if (i == 0) begin
            n_cmp++; if (LCD_DE !== 1'b1) begin n_fail++; $display("FAIL de_delay1: got %b want 1", LCD_DE); end
         end
         if (i == 100) begin
            n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== {5'd3, 6'd59, 5'd0}) begin n_fail++; $display("FAIL grad_100_479: got %h want %h", {LCD_R, LCD_G, LCD_B}, {5'd3, 6'd59, 5'd0}); end
         end
         if (i == 799) begin
            n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== {5'd24, 6'd59, 5'd0}) begin n_fail++; $display("FAIL grad_799_479: got %h want %h", {LCD_R, LCD_G, LCD_B}, {5'd24, 6'd59, 5'd0}); end
         end
      end
      TG_DE = 1'b0; step();
      n_cmp++; if (LCD_DE !== 1'b0) begin n_fail++; $display("FAIL de_fall_delay1: got %b want 0", LCD_DE); end
      TG_HSYNC = 1'b0;
      n_cmp++; if (LCD_HSYNC !== 1'b1) begin n_fail++; $display("FAIL hs_not_early: got %b want 1", LCD_HSYNC); end
      step();
      n_cmp++; if (LCD_HSYNC !== 1'b0) begin n_fail++; $display("FAIL hs_delay1: got %b want 0", LCD_HSYNC); end
      TG_HSYNC = 1'b1; step();
      n_cmp++; if (LCD_HSYNC !== 1'b1) begin n_fail++; $display("FAIL hs_release: got %b want 1", LCD_HSYNC); end
      TG_VSYNC = 1'b0;
      n_cmp++; if (LCD_VSYNC !== 1'b1) begin n_fail++; $display("FAIL vs_not_early: got %b want 1", LCD_VSYNC); end
      step();
      n_cmp++; if (LCD_VSYNC !== 1'b0) begin n_fail++; $display("FAIL vs_delay1: got %b want 0", LCD_VSYNC); end
      TG_VSYNC = 1'b1; step();
      n_cmp++; if (LCD_VSYNC !== 1'b1) begin n_fail++; $display("FAIL vs_release: got %b want 1", LCD_VSYNC); end
   endtask

   task automatic test_auto();
      RST = 1'b1; step();
      RST = 1'b0; AUTO = 1'b1; step();
      for (int k = 0; k < 20; k++) begin
         frame_start(1'b0);
         n_cmp++; if (PATTERN !== 3'(exp_pat[k])) begin n_fail++; $display("FAIL auto_pat[%0d]: got %0d want %0d", k, PATTERN, exp_pat[k]); end
         run_line(701, 700, rgb);
         n_cmp++; if (rgb !== (exp_blk[k] ? 16'h0 : exp_rgb700[exp_pat[k]])) begin n_fail++; $display("FAIL auto_rgb[%0d]: got %h want %h", k, rgb, exp_blk[k] ? 16'h0 : exp_rgb700[exp_pat[k]]); end
      end
      AUTO = 1'b0; step();
   endtask

   task automatic test_reset_in_blank();
      frame_start(1'b1);
      frame_start(1'b0);
      frame_start(1'b1);
      n_cmp++; if (PATTERN !== 3'd3) begin n_fail++; $display("FAIL pre_reset_pat: got %0d want 3", PATTERN); end
      TG_DE = 1'b1; TG_HSYNC = 1'b0; TG_VSYNC = 1'b0; RST = 1'b1; step();
      n_cmp++; if (LCD_DE !== 1'b0) begin n_fail++; $display("FAIL midrst_de: got %b want 0", LCD_DE); end
      n_cmp++; if (LCD_HSYNC !== 1'b1) begin n_fail++; $display("FAIL midrst_hs: got %b want 1", LCD_HSYNC); end
      n_cmp++; if (LCD_VSYNC !== 1'b1) begin n_fail++; $display("FAIL midrst_vs: got %b want 1", LCD_VSYNC); end
      n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== 16'h0) begin n_fail++; $display("FAIL midrst_rgb: got %h want 0000", {LCD_R, LCD_G, LCD_B}); end
      n_cmp++; if (PATTERN !== 3'd0) begin n_fail++; $display("FAIL midrst_pat: got %0d want 0", PATTERN); end
      n_cmp++; if (FRAME_CNT !== 16'd0) begin n_fail++; $display("FAIL midrst_fcnt: got %0d want 0", FRAME_CNT); end
      RST = 1'b0; TG_DE = 1'b0; TG_HSYNC = 1'b1; TG_VSYNC = 1'b1; step();
      run_line(701, 700, rgb);
      n_cmp++; if (rgb !== 16'h0) begin n_fail++; $display("FAIL midrst_wait_vs: got %h want 0000", rgb); end
   endtask

   task automatic test_x_saturation();
      frame_start(1'b0);
      frame_start(1'b1);
      frame_start(1'b1);
      n_cmp++; if (PATTERN !== 3'd1) begin n_fail++; $display("FAIL blank_req_pat: got %0d want 1", PATTERN); end
      frame_start(1'b0);
      n_cmp++; if (PATTERN !== 3'd2) begin n_fail++; $display("FAIL blank_req_served: got %0d want 2", PATTERN); end
      frame_start(1'b0);
      for (int i = 0; i < 900; i++) begin
         TG_DE = 1'b1; step();
         if (i == 799) begin
            n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== 16'hC000) begin n_fail++; $display("FAIL xsat_799: got %h want c000", {LCD_R, LCD_G, LCD_B}); end
         end
      end
      n_cmp++; if ({LCD_R, LCD_G, LCD_B} !== 16'hC000) begin n_fail++; $display("FAIL xsat_899: got %h want c000", {LCD_R, LCD_G, LCD_B}); end
      n_cmp++; if (LCD_DE !== 1'b1) begin n_fail++; $display("FAIL xsat_de: got %b want 1", LCD_DE); end
      TG_DE = 1'b0; step(); step();
   endtask

   initial begin
      test_reset();
      test_first_frames();
      test_button();
      test_back_to_back_requests();
      test_gradient_timing();
      test_auto();
      test_reset_in_blank();
      test_x_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_pattern_scheduler.md
# lcd_pattern_scheduler

Frame-synchronous test-pattern scheduler for the 800x480 RGB565 LCD path. It sits between the LCD timing generator and the panel pins. It takes the generator's DE/HSYNC/VSYNC and derives pixel coordinates from them. It picks one of five patterns, switching only at frame boundaries, either from a button request or automatically every N frames. It drives registered, sync-aligned RGB565 data to the panel.

## Interface
Parameters:
- H_ACTIVE, 800: active pixels per line
- V_ACTIVE, 480: active lines per frame
- FRAMES_PER_PATTERN, 60: frames per pattern in auto mode; legal range 1..65535
- NUM_PATTERNS, 5: pattern count; pattern index wraps to 0 after NUM_PATTERNS-1

Ports:
- PixelClk  in  1  pixel clock; the only clock
- RST  in  1  reset; synchronous and active-high
- TG_DE  in  1  data enable from the timing generator
- TG_HSYNC  in  1  HSYNC from the timing generator, active low
- TG_VSYNC  in  1  VSYNC from the timing generator, active low
- BTN_NEXT  in  1  single-cycle request to advance the pattern, already synchronised
- AUTO  in  1  enables automatic advance when 1
- LCD_DE  out  1  TG_DE delayed by 1 cycle
- LCD_HSYNC  out  1  TG_HSYNC delayed by 1 cycle
- LCD_VSYNC  out  1  TG_VSYNC delayed by 1 cycle
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue
- PATTERN  out  3  pattern index currently on screen
- FRAME_CNT  out  16  frame counter within the current pattern

## Operation
- Frame start (FS): one-cycle strobe on the falling edge of TG_VSYNC (previous sample 1, current sample 0).
- x counter (11 b):
  - Cleared whenever TG_DE=0.
  - Increments on each TG_DE=1 cycle.
  - Saturates at H_ACTIVE-1.
- y counter (10 b):
  - Cleared on FS.
  - Increments on each falling edge of TG_DE.
  - Saturates at V_ACTIVE-1.
- Pending request flag:
  - Set by BTN_NEXT=1.
  - Set at FS when AUTO=1 and FRAME_CNT==FRAMES_PER_PATTERN-1.
  - Cleared when a switch is taken.
  - Multiple requests within one frame collapse into a single advance.
- FSM states:
  - WAIT_VS: reset state. RGB output is 0. Moves to SHOW on the first FS.
  - SHOW: pattern output. At FS: if pending=1, move to BLANK, set PATTERN to (PATTERN+1) mod NUM_PATTERNS, set FRAME_CNT=0. Otherwise FRAME_CNT increments, saturating at 0xFFFF.
  - BLANK: exactly one black frame. Moves to SHOW at the next FS. FRAME_CNT stays 0 and then counts normally from the first SHOW frame.
- Requests arriving during BLANK set pending and are served at the first FS in SHOW, which gives one more BLANK frame.
- Patterns (x, y are the coordinates of the current input pixel):
  - 0, colour bars: b = x / (H_ACTIVE/8), computed with a comparator chain (no divider). R = b[2] ? 5'h1F : 0; G = b[1] ? 6'h3F : 0; B = b[0] ? 5'h1F : 0. Bar 0 is black, bar 7 is white.
  - 1, grid: white (1F/3F/1F) when x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1. Black otherwise.
  - 2, gradient: R = x[9:5]; G = y[8:3]; B = 0.
  - 3, checkerboard: white when x[5]^y[5]=1, black otherwise.
  - 4, solid red: R = 5'h1F; G = 0; B = 0.
- RGB is forced to 0 whenever the delayed DE is 0 and in states WAIT_VS and BLANK.

## Timing
- Reset values: LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, PATTERN=0, FRAME_CNT=0, state=WAIT_VS, pending=0, x=0, y=0, sync-history registers=1.
- All outputs are registered.
- LCD_DE, LCD_HSYNC, LCD_VSYNC and RGB share a fixed latency of 1 cycle from the TG_* inputs. The pixel at input cycle t appears at t+1, aligned with LCD_DE.
- FS, the state change, the PATTERN update and the FRAME_CNT update all occur in the cycle after the TG_VSYNC falling edge is sampled.
- Pixels output during that update cycle already use the new state.
- A BTN_NEXT coinciding with FS joins the decision at that FS; the switch is taken at that FS.
- A mid-operation RST=1 restores all reset values on the next edge, whatever the state.

## Test plan
- Reset, then 3 frames with AUTO=0 and no button -> PATTERN=0. Output RGB=0 until the first FS. Then pixel x=0 outputs 0/0/0 and x=700 outputs 1F/3F/1F. FRAME_CNT reads 1 in the 3rd frame.
- Press BTN_NEXT mid-frame in SHOW -> at the next FS, PATTERN=1 and a full BLANK frame of RGB=0 follows. The next frame shows the grid: (0,0) white, (1,1) black, (32,5) white.
- AUTO=1, FRAMES_PER_PATTERN=2, run 20 frames -> PATTERN steps through 0,1,2,3,4,0 in order, wrapping from 4 to 0. Each switch is followed by exactly one black frame.
- Press BTN_NEXT three times in one frame, plus once at the FS cycle -> exactly one advance of PATTERN.
- Gradient pattern, pixel (x=799, y=479) -> R=5'd24, G=6'd59, B=0, appearing exactly 1 cycle after the input pixel. LCD_DE, LCD_HSYNC and LCD_VSYNC match the inputs delayed by 1 cycle.
- Assert RST while in BLANK with PATTERN=3 -> next cycle all outputs are at reset values and the state is WAIT_VS. Hold TG_DE high for 900 cycles -> x saturates at 799 with no wrap.
